// File: rtl/avg_frame_feeder.sv
// avg_frame_feeder: buffers an N_BYTES frame, replays it into the averaging core, and returns W on a valid/ready port.
// Optional DONE_TIMEOUT_EN adds a WAIT_DONE watchdog that aborts with a zero result and a sticky timeout_err.
module avg_frame_feeder #(
   parameter int DATA_W         = 8,
   parameter int N_BYTES        = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              start,
   output logic [DATA_W-1:0] data,
   input  logic              done,
   input  logic [DATA_W-1:0] W,
   output logic [DATA_W-1:0] res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              timeout_err
);
   localparam int CW = $clog2(N_BYTES);
   localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);
   typedef enum logic [1:0] {FILL, SEND, WAIT_DONE, HOLD} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] mem [N_BYTES];
   assign in_ready = state == FILL;
   always_ff @(posedge clock)
      if (in_valid && in_ready) mem[cnt] <= in_data;
`ifdef DONE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd;
   logic expired;
   assign expired = wd == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clock)
      if (reset) wd <= '0;
      else wd <= state == WAIT_DONE ? wd + 1'b1 : '0;
`else
   assign timeout_err = 1'b0;
`endif
   always_ff @(posedge clock)
      if (reset) begin
         state     <= FILL;
         cnt       <= '0;
         start     <= 1'b0;
         data      <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef DONE_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
      end else
         case (state)
            FILL:
               if (in_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state <= SEND;
                     busy  <= 1'b1;
                     start <= 1'b1;
                     data  <= mem[0];
                  end
               end
            SEND: begin
               start <= 1'b0;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= WAIT_DONE;
                  data  <= '0;
               end else
                  data <= mem[cnt + 1'b1];
            end
            WAIT_DONE:
               if (done) begin
                  res_data  <= W;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end
`ifdef DONE_TIMEOUT_EN
               else if (expired) begin
                  timeout_err <= 1'b1;
                  res_data    <= '0;
                  res_valid   <= 1'b1;
                  state       <= HOLD;
               end
`endif
            HOLD:
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= FILL;
               end
         endcase
endmodule

// File: tb/tb_avg_frame_feeder.sv
// tb_avg_frame_feeder: randomized frames checked against a frame-level model of fill/replay/result handshake.
module tb_avg_frame_feeder;
   localparam int NB = 8;
   localparam int TO = 16;
   logic clock = 1'b0, reset = 1'b1;
   logic [7:0] in_data = '0, W = '0;
   logic in_valid = 1'b0, done = 1'b0, res_ready = 1'b0;
   logic in_ready, start, res_valid, busy, timeout_err;
   logic [7:0] data, res_data;
   int n_checks = 0, n_fail = 0;
   logic exp_err = 1'b0;
   always #5 clock = ~clock;
   avg_frame_feeder #(.DATA_W(8), .N_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .start(start), .data(data), .done(done), .W(W), .res_data(res_data), .res_valid(res_valid),
      .res_ready(res_ready), .busy(busy), .timeout_err(timeout_err)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_start"}, start, 0);
      check({tag, "_data"}, data, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_timeout_err"}, timeout_err, exp_err);
   endtask
   task automatic fill(input logic [7:0] b [NB], input int mode, input int limit);
      int idx = 0, cyc = 0;
      while (idx < limit && cyc < 200) begin
         check("fill_in_ready", in_ready, 1);
         check("fill_busy", busy, 0);
         check("fill_res_valid", res_valid, 0);
         in_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         in_data = in_valid ? b[idx] : 8'($urandom);
         res_ready = 1'($urandom_range(0, 1));
         tick();
         if (in_valid) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      res_ready = 1'b0;
      if (idx < limit) check("fill_budget", idx, limit);
   endtask
   task automatic replay(input logic [7:0] b [NB], input bit spur);
      for (int k = 0; k < NB; k++) begin
         check("send_start", start, k == 0);
         check("send_data", data, b[k]);
         check("send_busy", busy, 1);
         check("send_in_ready", in_ready, 0);
         done = spur && k == NB - 2;
         W = 8'd55;
         tick();
      end
      done = 1'b0;
      check("wait_start", start, 0);
      check("wait_data", data, 0);
      check("wait_busy", busy, 1);
   endtask
   task automatic finish_done(input int lat, input logic [7:0] w);
      repeat (lat) begin
         check("wait_res_valid", res_valid, 0);
         tick();
      end
      done = 1'b1;
      W = w;
      tick();
      done = 1'b0;
      W = 8'($urandom);
      check("res_valid", res_valid, 1);
      check("res_data", res_data, w);
      check("timeout_err", timeout_err, exp_err);
   endtask
   task automatic drain(input int hold, input logic [7:0] w);
      for (int i = 0; i < hold; i++) begin
         res_ready = 1'b0;
         done = i == 0;
         W = 8'd33;
         check("hold_res_valid", res_valid, 1);
         check("hold_res_data", res_data, w);
         check("hold_in_ready", in_ready, 0);
         check("hold_busy", busy, 1);
         tick();
      end
      done = 1'b0;
      res_ready = 1'b1;
      check("hs_res_valid", res_valid, 1);
      check("hs_res_data", res_data, w);
      check("hs_in_ready", in_ready, 0);
      tick();
      res_ready = 1'b0;
      check("post_res_valid", res_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
   endtask
   task automatic run_frame(input logic [7:0] b [NB], input int mode, input int lat, input int hold,
                            input bit spur, input logic [7:0] w);
      fill(b, mode, NB);
      replay(b, spur);
      finish_done(lat, w);
      drain(hold, w);
   endtask
   initial begin
      logic [7:0] f1 [NB];
      logic [7:0] f2 [NB];
      logic [7:0] fr [NB];
      f1 = '{8'd10, 8'd200, 8'd50, 8'd3, 8'd77, 8'd90, 8'd120, 8'd8};
      f2 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      tick();
      tick();
      check_idle("reset");
      reset = 1'b0;
      run_frame(f1, 0, 1, 5, 1'b0, 8'd101);
      run_frame(f1, 1, 1, 0, 1'b0, 8'd101);
      for (int i = 0; i < NB; i++) fr[i] = 8'($urandom);
      fill(fr, 0, 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("midreset");
      run_frame(f2, 0, 2, 1, 1'b0, 8'd77);
      run_frame(f1, 2, 3, 1, 1'b1, 8'd9);
      repeat (10) begin
         for (int i = 0; i < NB; i++) fr[i] = 8'($urandom);
         run_frame(fr, $urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), 8'($urandom));
      end
`ifdef DONE_TIMEOUT_EN
      run_frame(f2, 0, TO - 1, 1, 1'b0, 8'd200);
      fill(f1, 0, NB);
      replay(f1, 1'b0);
      repeat (TO - 1) begin
         check("to_res_valid_early", res_valid, 0);
         tick();
      end
      tick();
      exp_err = 1'b1;
      check("to_res_valid", res_valid, 1);
      check("to_res_data", res_data, 0);
      check("to_err", timeout_err, 1);
      drain(2, 8'd0);
      run_frame(f2, 1, 2, 0, 1'b0, 8'd42);
      check("to_err_sticky", timeout_err, 1);
`else
      run_frame(f2, 0, 80, 0, 1'b0, 8'd123);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
